conv_frame_ctrl: RTL

// Frame sequencer for the 3x3 window line-buffer of the convolution engine.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_frame_ctrl_if.sv | 31 +++
 rtl/conv_raster_cnt.sv | 43 ++++
 rtl/conv_frame_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing for the convolution frame sequencer
package conv_pkg;

    localparam int W     = 128;
    localparam int MAX_H = 128;
    localparam int XW    = $clog2(W);
    localparam int YW    = $clog2(MAX_H + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAD_ROW = 2'd2,
        CLEAR   = 2'd3
    } state_t;

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// rtl/conv_frame_ctrl_if.sv - pixel input, line-buffer and window ports of the frame sequencer
interface conv_frame_ctrl_if #(
    parameter int XW = conv_pkg::XW,
    parameter int YW = conv_pkg::YW
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic          buf_ena;
    logic [7:0]    buf_pixel;
    logic          buf_rst_n;
    logic          win_valid;
    logic          win_ready;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          win_sof;
    logic          win_eol;
    logic          win_eof;

    modport master (
        input  in_valid, in_pixel, win_ready,
        output in_ready, buf_ena, buf_pixel, buf_rst_n,
               win_valid, win_x, win_y, win_sof, win_eol, win_eof
    );

    modport slave (
        output in_valid, in_pixel, win_ready,
        input  in_ready, buf_ena, buf_pixel, buf_rst_n,
               win_valid, win_x, win_y, win_sof, win_eol, win_eof
    );
endinterface

// File: rtl/conv_raster_cnt.sv
// rtl/conv_raster_cnt.sv - slot/row raster counter with wrap and height compare
module conv_raster_cnt #(
    parameter int W  = conv_pkg::W,
    parameter int XW = conv_pkg::XW,
    parameter int YW = conv_pkg::YW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    input  logic [YW-1:0] rows,
    output logic [XW-1:0] slot,
    output logic [YW-1:0] row,
    output logic          slot_last,
    output logic          slot_nz,
    output logic          row_nz,
    output logic          row_next_end
);

    assign slot_last    = (slot == XW'(W - 1));
    assign slot_nz      = (slot != '0);
    assign row_nz       = (row != '0);
    // true while pushing the last real row; its wrap lands on the pad row
    assign row_next_end = ((row + 1'b1) == rows);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot <= '0;
            row  <= '0;
        end else if (clear) begin
            slot <= '0;
            row  <= '0;
        end else if (step) begin
            if (slot_last) begin
                slot <= '0;
                row  <= row + 1'b1;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// rtl/conv_frame_ctrl.sv - frame sequencer feeding the 3x3 line-buffer and tagging output windows
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int W     = conv_pkg::W,
    parameter int MAX_H = conv_pkg::MAX_H,
    parameter int XW    = $clog2(W),
    parameter int YW    = $clog2(MAX_H + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [YW-1:0] cfg_rows,
    output logic          busy,
    output logic          frame_done,
    conv_frame_ctrl_if.master bus
);

    state_t        state;
    logic [YW-1:0] h_rows;
    logic [XW-1:0] slot;
    logic [YW-1:0] row;
    logic          slot_last, slot_nz, row_nz, row_next_end;
    logic          start_ok, adv, push, take_in;
    logic [7:0]    push_pixel;

    logic          buf_rst_n_q;
    logic          win_valid_q, win_sof_q, win_eol_q, win_eof_q;
    logic [XW-1:0] win_x_q;
    logic [YW-1:0] win_y_q;

    assign start_ok = start && (cfg_rows != '0) && (cfg_rows <= YW'(MAX_H));

    conv_raster_cnt #(.W(W), .XW(XW), .YW(YW)) u_cnt (
        .clock        (clock),
        .reset        (reset),
        .clear        ((state == IDLE) && start_ok),
        .step         (push),
        .rows         (h_rows),
        .slot         (slot),
        .row          (row),
        .slot_last    (slot_last),
        .slot_nz      (slot_nz),
        .row_nz       (row_nz),
        .row_next_end (row_next_end)
    );

    // one-deep output stage: a push may replace the window only once it is taken
    assign adv = !win_valid_q || bus.win_ready;

    always_comb begin
        push       = 1'b0;
        take_in    = 1'b0;
        push_pixel = 8'd0;
        case (state)
            RUN: begin
                if (!slot_last) begin
                    take_in    = adv;
                    push       = adv && bus.in_valid;
                    push_pixel = bus.in_pixel;
                end else begin
                    push = adv;
                end
            end
            PAD_ROW: push = adv;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            h_rows      <= '0;
            buf_rst_n_q <= 1'b1;
            frame_done  <= 1'b0;
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
            win_eof_q   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        h_rows <= cfg_rows;
                    end
                end
                RUN: begin
                    if (push && slot_last && row_next_end) state <= PAD_ROW;
                end
                PAD_ROW: begin
                    if (push && slot_last) begin
                        state       <= CLEAR;
                        buf_rst_n_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    state       <= IDLE;
                    buf_rst_n_q <= 1'b1;
                    frame_done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // slot-0 pushes only load left-pad context, so they never produce a window
            if (push) begin
                win_valid_q <= slot_nz && row_nz;
                win_x_q     <= slot - 1'b1;
                win_y_q     <= row - 1'b1;
                win_sof_q   <= (slot == XW'(1)) && (row == YW'(1));
                win_eol_q   <= slot_last && row_nz;
                win_eof_q   <= slot_last && (state == PAD_ROW);
            end else if (win_valid_q && bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign bus.in_ready  = take_in;
    assign bus.buf_ena   = push;
    assign bus.buf_pixel = push_pixel;
    assign bus.buf_rst_n = buf_rst_n_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_x     = win_x_q;
    assign bus.win_y     = win_y_q;
    assign bus.win_sof   = win_sof_q;
    assign bus.win_eol   = win_eol_q;
    assign bus.win_eof   = win_eof_q;

endmodule
